// File: rtl/spi_flash_responder.sv
// SPI mode-0 serial flash target.
// SCLK/CS_N/MOSI are oversampled in the clk domain. The block decodes READ (0x03),
// JEDEC ID (0x9F) and READ STATUS (0x05), and serves read data from a byte-wide
// memory port that has a fixed one-clock read latency.
module spi_flash_responder #(
    parameter int          ADDR_W      = 24,
    parameter logic [23:0] JEDEC_ID    = 24'hEF4016,
    parameter int          SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              spi_sclk,
    input  logic              spi_cs_n,
    input  logic              spi_mosi,
    output logic              spi_miso,
    output logic              spi_miso_oe,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    input  logic [7:0]        mem_data,
    output logic              busy,
    output logic              cmd_err
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CMD    = 3'd1,
        ST_ADDR   = 3'd2,
        ST_DATA   = 3'd3,
        ST_ID     = 3'd4,
        ST_STATUS = 3'd5,
        ST_IGNORE = 3'd6
    } state_t;

    logic [SYNC_STAGES-1:0] sclk_sync_r;
    logic [SYNC_STAGES-1:0] cs_sync_r;
    logic [SYNC_STAGES-1:0] mosi_sync_r;
    logic                   sclk_prev_r;
    logic                   cs_prev_r;

    logic sclk_s;
    logic cs_s;
    logic mosi_s;
    logic sclk_rise_s;
    logic sclk_fall_s;
    logic cs_fall_s;

    state_t            state_r,      state_nx;
    logic [4:0]        bit_cnt_r,    bit_cnt_nx;
    logic [22:0]       addr_shift_r, addr_shift_nx;
    logic [7:0]        shift_r,      shift_nx;
    logic [7:0]        next_byte_r,  next_byte_nx;
    logic [ADDR_W-1:0] mem_addr_r,   mem_addr_nx;
    logic              mem_rd_r,     mem_rd_nx;
    logic              rd_pend_r;
    logic              miso_oe_r,    miso_oe_nx;
    logic              cmd_err_r,    cmd_err_nx;
    logic              busy_r;
    logic [1:0]        id_idx_r,     id_idx_nx;

    logic [23:0]       shift_in_s;
    logic [7:0]        load_byte_s;

    // Synchronise the SPI pins into clk; CS_N chain idles deasserted (high).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_sync_r <= {SYNC_STAGES{1'b0}};
            cs_sync_r   <= {SYNC_STAGES{1'b1}};
            mosi_sync_r <= {SYNC_STAGES{1'b0}};
        end else begin
            sclk_sync_r <= {sclk_sync_r[SYNC_STAGES-2:0], spi_sclk};
            cs_sync_r   <= {cs_sync_r[SYNC_STAGES-2:0], spi_cs_n};
            mosi_sync_r <= {mosi_sync_r[SYNC_STAGES-2:0], spi_mosi};
        end
    end

    assign sclk_s = sclk_sync_r[SYNC_STAGES-1];
    assign cs_s   = cs_sync_r[SYNC_STAGES-1];
    assign mosi_s = mosi_sync_r[SYNC_STAGES-1];

    // Previous synced levels, used to turn the pin levels into edge pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_prev_r <= 1'b0;
            cs_prev_r   <= 1'b1;
        end else begin
            sclk_prev_r <= sclk_s;
            cs_prev_r   <= cs_s;
        end
    end

    assign sclk_rise_s = sclk_s & ~sclk_prev_r;
    assign sclk_fall_s = ~sclk_s & sclk_prev_r;
    assign cs_fall_s   = ~cs_s & cs_prev_r;

    // Incoming MOSI bit appended to the command/address shift register.
    assign shift_in_s = {addr_shift_r, mosi_s};

    // Byte presented to the output shifter at each byte boundary, by state.
    always_comb begin
        load_byte_s = 8'h00;
        case (state_r)
            ST_DATA: load_byte_s = next_byte_r;
            ST_ID: begin
                case (id_idx_r)
                    2'd0:    load_byte_s = JEDEC_ID[23:16];
                    2'd1:    load_byte_s = JEDEC_ID[15:8];
                    2'd2:    load_byte_s = JEDEC_ID[7:0];
                    default: load_byte_s = 8'h00;
                endcase
            end
            default: load_byte_s = 8'h00;
        endcase
    end

    // Next-state and datapath decode; a deasserted CS overrides every state.
    always_comb begin
        state_nx      = state_r;
        bit_cnt_nx    = bit_cnt_r;
        addr_shift_nx = addr_shift_r;
        shift_nx      = shift_r;
        mem_addr_nx   = mem_addr_r;
        mem_rd_nx     = 1'b0;
        miso_oe_nx    = miso_oe_r;
        cmd_err_nx    = 1'b0;
        id_idx_nx     = id_idx_r;

        // Memory data arrives one clk after the strobe; capture it then.
        if (rd_pend_r) begin
            next_byte_nx = mem_data;
        end else begin
            next_byte_nx = next_byte_r;
        end

        if (cs_s) begin
            state_nx   = ST_IDLE;
            bit_cnt_nx = 5'd0;
            miso_oe_nx = 1'b0;
            shift_nx   = 8'h00;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (cs_fall_s) begin
                        state_nx      = ST_CMD;
                        bit_cnt_nx    = 5'd0;
                        addr_shift_nx = 23'd0;
                        id_idx_nx     = 2'd0;
                    end else begin
                        state_nx = ST_IDLE;
                    end
                end
                ST_CMD: begin
                    if (sclk_rise_s) begin
                        addr_shift_nx = shift_in_s[22:0];
                        if (bit_cnt_r == 5'd7) begin
                            bit_cnt_nx = 5'd0;
                            case (shift_in_s[7:0])
                                8'h03:   state_nx = ST_ADDR;
                                8'h9F:   state_nx = ST_ID;
                                8'h05:   state_nx = ST_STATUS;
                                default: begin
                                    state_nx   = ST_IGNORE;
                                    cmd_err_nx = 1'b1;
                                end
                            endcase
                        end else begin
                            bit_cnt_nx = bit_cnt_r + 5'd1;
                        end
                    end else begin
                        state_nx = ST_CMD;
                    end
                end
                ST_ADDR: begin
                    if (sclk_rise_s) begin
                        addr_shift_nx = shift_in_s[22:0];
                        if (bit_cnt_r == 5'd23) begin
                            bit_cnt_nx  = 5'd0;
                            mem_addr_nx = shift_in_s[ADDR_W-1:0];
                            mem_rd_nx   = 1'b1;
                            state_nx    = ST_DATA;
                        end else begin
                            bit_cnt_nx = bit_cnt_r + 5'd1;
                        end
                    end else begin
                        state_nx = ST_ADDR;
                    end
                end
                ST_DATA, ST_ID, ST_STATUS: begin
                    if (sclk_fall_s) begin
                        // Counter low bits are zero only on the fall that starts a byte.
                        if (bit_cnt_r[2:0] == 3'd0) begin
                            shift_nx   = load_byte_s;
                            miso_oe_nx = 1'b1;
                            if ((state_r == ST_ID) && (id_idx_r != 2'd3)) begin
                                id_idx_nx = id_idx_r + 2'd1;
                            end else begin
                                id_idx_nx = id_idx_r;
                            end
                        end else begin
                            shift_nx = {shift_r[6:0], 1'b0};
                        end
                    end else if (sclk_rise_s) begin
                        bit_cnt_nx = bit_cnt_r + 5'd1;
                        // Bit 0 of a READ byte sampled: prefetch the following byte.
                        if ((state_r == ST_DATA) && (bit_cnt_r[2:0] == 3'd7)) begin
                            mem_addr_nx = mem_addr_r + {{(ADDR_W-1){1'b0}}, 1'b1};
                            mem_rd_nx   = 1'b1;
                        end else begin
                            mem_rd_nx = 1'b0;
                        end
                    end else begin
                        state_nx = state_r;
                    end
                end
                ST_IGNORE: begin
                    miso_oe_nx = 1'b0;
                end
                default: begin
                    state_nx   = ST_IDLE;
                    bit_cnt_nx = 5'd0;
                end
            endcase
        end
    end

    // State and datapath registers; all outputs come straight from here.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= ST_IDLE;
            bit_cnt_r    <= 5'd0;
            addr_shift_r <= 23'd0;
            shift_r      <= 8'h00;
            next_byte_r  <= 8'h00;
            mem_addr_r   <= {ADDR_W{1'b0}};
            mem_rd_r     <= 1'b0;
            rd_pend_r    <= 1'b0;
            miso_oe_r    <= 1'b0;
            cmd_err_r    <= 1'b0;
            busy_r       <= 1'b0;
            id_idx_r     <= 2'd0;
        end else begin
            state_r      <= state_nx;
            bit_cnt_r    <= bit_cnt_nx;
            addr_shift_r <= addr_shift_nx;
            shift_r      <= shift_nx;
            next_byte_r  <= next_byte_nx;
            mem_addr_r   <= mem_addr_nx;
            mem_rd_r     <= mem_rd_nx;
            rd_pend_r    <= mem_rd_r;
            miso_oe_r    <= miso_oe_nx;
            cmd_err_r    <= cmd_err_nx;
            busy_r       <= (state_nx != ST_IDLE);
            id_idx_r     <= id_idx_nx;
        end
    end

    assign spi_miso    = shift_r[7];
    assign spi_miso_oe = miso_oe_r;
    assign mem_addr    = mem_addr_r;
    assign mem_rd      = mem_rd_r;
    assign busy        = busy_r;
    assign cmd_err     = cmd_err_r;

endmodule
